// File: rtl/pipe_if_stage_if.sv
// Instruction-memory fetch interface.
// One req/ack handshake between the fetch stage and instruction memory.
//   req   : fetch request; the address is valid while req is high
//   addr  : fetch address
//   ack   : read data valid this cycle; may rise in the same cycle as req
//   rdata : instruction word, valid while ack is high
interface pipe_if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, picks the next PC from pcsource, fetches over a req/ack
// instruction-memory handshake, and presents inst/dpc4 to the ID stage.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   pcsource         : next-PC select (00 pc+4, 01 bpc, 10 rpc, 11 jpc)
//   bpc, rpc, jpc    : branch / register / jump targets
//   we_pc_ir         : 1 = PC/IR may advance, 0 = hold
//   reset_ir         : 1 = IR loads the bubble word at the next edge
//   imem             : instruction-memory master port (req/addr/ack/rdata)
//   pc, pc4          : current fetch PC and PC + 4
//   inst, dpc4       : IF/ID instruction register and its PC + 4
// Optional feature macro IF_PERF_EN: adds fetch_cnt and stall_cnt counters.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             pcsource,
    input  logic [31:0]            bpc,
    input  logic [31:0]            rpc,
    input  logic [31:0]            jpc,
    input  logic                   we_pc_ir,
    input  logic                   reset_ir,
    pipe_if_stage_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            pc4,
    output logic [31:0]            inst,
    output logic [31:0]            dpc4
`ifdef IF_PERF_EN
    ,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {FETCH, HOLD} state_t;

    // What the IR does at the next edge
    typedef enum logic [2:0] {
        IR_KEEP,
        IR_MEM,
        IR_BUF,
        IR_BUBBLE,
        IR_CLEAR
    } ir_sel_t;

    state_t          state_q;
    state_t          state_d;
    ir_sel_t         ir_sel;
    logic            pc_load;
    logic            buf_load;
    logic [XLEN-1:0] sel_tgt;
    logic [XLEN-1:0] npc;
    logic            redir_pend;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] buf_word;
    logic [XLEN-1:0] buf_pc4;

    // Next-PC mux; a redirect latched while the PC was stalled wins
    always_comb begin
        sel_tgt = pc4;
        unique case (pcsource)
            2'b00: sel_tgt = pc4;
            2'b01: sel_tgt = bpc;
            2'b10: sel_tgt = rpc;
            2'b11: sel_tgt = jpc;
            default: sel_tgt = pc4;
        endcase
        npc = redir_pend ? redir_tgt : sel_tgt;
    end

    assign imem.req  = (state_q == FETCH) & ~reset;
    assign imem.addr = pc;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and datapath controls
    always_comb begin
        state_d  = state_q;
        pc_load  = 1'b0;
        buf_load = 1'b0;
        ir_sel   = IR_KEEP;
        unique case (state_q)
            FETCH: begin
                if (imem.ack) begin
                    if (we_pc_ir) begin
                        pc_load = 1'b1;
                        ir_sel  = IR_MEM;
                    end else begin
                        // ID stalled: park the word so it is not lost
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (we_pc_ir) begin
                    ir_sel = IR_BUBBLE;
                end
            end
            HOLD: begin
                if (we_pc_ir) begin
                    pc_load = 1'b1;
                    ir_sel  = IR_BUF;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        // IR flush from ID overrides any IR load; PC/FSM unaffected
        if (reset_ir) begin
            ir_sel = IR_CLEAR;
        end
    end

    // PC, redirect latch, hold buffer and IF/ID register
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            pc4        <= RESET_PC + 32'd4;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
            buf_word   <= NOP_WORD;
            buf_pc4    <= '0;
            inst       <= NOP_WORD;
            dpc4       <= '0;
        end else begin
            if (pc_load) begin
                pc  <= npc;
                pc4 <= npc + 32'd4;
            end

            // Remember a redirect issued while the PC could not move;
            // the in-flight (delay-slot) fetch still completes
            if (pc_load) begin
                redir_pend <= 1'b0;
            end else if (pcsource != 2'b00) begin
                redir_pend <= 1'b1;
                redir_tgt  <= sel_tgt;
            end

            if (buf_load) begin
                buf_word <= imem.rdata;
                buf_pc4  <= pc4;
            end

            unique case (ir_sel)
                IR_MEM: begin
                    inst <= imem.rdata;
                    dpc4 <= pc4;
                end
                IR_BUF: begin
                    inst <= buf_word;
                    dpc4 <= buf_pc4;
                end
                IR_BUBBLE: begin
                    inst <= NOP_WORD;
                end
                IR_CLEAR: begin
                    inst <= NOP_WORD;
                    dpc4 <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IF_PERF_EN
    // Accepted-fetch and stall-cycle counters, free-running and wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state_q == FETCH) && imem.ack) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!we_pc_ir) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: instruction memory returns a fixed
// word per address; the bench controls ack timing and the ID-side inputs.
module tb_pipe_if_stage;

    logic        clock;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        we_pc_ir;
    logic        reset_ir;
    logic        ack_drv;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] dpc4;
`ifdef IF_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_cmp;
    int n_fail;

    pipe_if_stage_if imem ();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem.ack   = ack_drv;
    assign imem.rdata = word_at(imem.addr);

    pipe_if_stage dut (
        .clock    (clock),
        .reset    (reset),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .we_pc_ir (we_pc_ir),
        .reset_ir (reset_ir),
        .imem     (imem),
        .pc       (pc),
        .pc4      (pc4),
        .inst     (inst),
        .dpc4     (dpc4)
`ifdef IF_PERF_EN
        ,
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pcsource = 2'b00;
        we_pc_ir = 1'b1;
        reset_ir = 1'b0;
        ack_drv  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pcsource = 2'b00;
        we_pc_ir = 1'b1;
        reset_ir = 1'b0;
        ack_drv  = 1'b1;
        tick();
        n_cmp++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rst_req actual=%b required=0", imem.req); end
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc actual=%h required=0", pc); end
        n_cmp++; if (pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4 actual=%h required=4", pc4); end
        n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst actual=%h required=0", inst); end
        n_cmp++; if (dpc4 !== 32'h0) begin n_fail++; $display("FAIL rst_dpc4 actual=%h required=0", dpc4); end
        reset   = 1'b0;
        ack_drv = 1'b0;
        #1;
        n_cmp++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL rst_req_after actual=%b required=1", imem.req); end
        n_cmp++; if (imem.addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr actual=%h required=0", imem.addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        ack_drv = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (pc !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_pc%0d actual=%h required=%h", k, pc, 32'(4 * k)); end
            n_cmp++; if (inst !== word_at(32'(4 * (k - 1)))) begin n_fail++; $display("FAIL zw_inst%0d actual=%h required=%h", k, inst, word_at(32'(4 * (k - 1)))); end
            n_cmp++; if (dpc4 !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_dpc4%0d actual=%h required=%h", k, dpc4, 32'(4 * k)); end
        end
        ack_drv = 1'b0;
    endtask

    task automatic test_wait();
        do_reset();
        ack_drv = 1'b1;
        tick();
        tick();
        ack_drv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL wait_inst%0d actual=%h required=0", k, inst); end
            n_cmp++; if (pc !== 32'h8) begin n_fail++; $display("FAIL wait_pc%0d actual=%h required=8", k, pc); end
            n_cmp++; if (imem.addr !== 32'h8 || imem.req !== 1'b1) begin n_fail++; $display("FAIL wait_addr%0d actual=%h/%b required=8/1", k, imem.addr, imem.req); end
        end
        ack_drv = 1'b1;
        tick();
        n_cmp++; if (inst !== word_at(32'h8)) begin n_fail++; $display("FAIL wait_inst_done actual=%h required=%h", inst, word_at(32'h8)); end
        n_cmp++; if (pc !== 32'hC || dpc4 !== 32'hC) begin n_fail++; $display("FAIL wait_pc_done actual=%h/%h required=c/c", pc, dpc4); end
        ack_drv = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        ack_drv = 1'b1;
        tick();
        we_pc_ir = 1'b0;
        tick();
        ack_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL hold_req%0d actual=%b required=0", k, imem.req); end
            n_cmp++; if (inst !== word_at(32'h0) || pc !== 32'h4) begin n_fail++; $display("FAIL hold_state%0d actual=%h/%h required=%h/4", k, inst, pc, word_at(32'h0)); end
            if (k < 2) tick();
        end
        we_pc_ir = 1'b1;
        tick();
        n_cmp++; if (inst !== word_at(32'h4)) begin n_fail++; $display("FAIL hold_release_inst actual=%h required=%h", inst, word_at(32'h4)); end
        n_cmp++; if (pc !== 32'h8 || dpc4 !== 32'h8) begin n_fail++; $display("FAIL hold_release_pc actual=%h/%h required=8/8", pc, dpc4); end
        n_cmp++; if (imem.req !== 1'b1) begin n_fail++; $display("FAIL hold_release_req actual=%b required=1", imem.req); end
    endtask

    task automatic test_jump();
        do_reset();
        ack_drv = 1'b1;
        tick();
        ack_drv  = 1'b0;
        pcsource = 2'b11;
        jpc      = 32'h100;
        tick();
        n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL jmp_pc_wait actual=%h required=4", pc); end
        pcsource = 2'b00;
        jpc      = 32'hDEAD_0000;
        ack_drv  = 1'b1;
        tick();
        n_cmp++; if (inst !== word_at(32'h4) || dpc4 !== 32'h8) begin n_fail++; $display("FAIL jmp_slot actual=%h/%h required=%h/8", inst, dpc4, word_at(32'h4)); end
        n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jmp_pc actual=%h required=100", pc); end
        tick();
        n_cmp++; if (pc !== 32'h104 || inst !== word_at(32'h100)) begin n_fail++; $display("FAIL jmp_target actual=%h/%h required=104/%h", pc, inst, word_at(32'h100)); end
        ack_drv = 1'b0;
    endtask

    task automatic test_redir_overwrite();
        do_reset();
        ack_drv  = 1'b0;
        pcsource = 2'b01;
        bpc      = 32'h200;
        tick();
        pcsource = 2'b10;
        rpc      = 32'h300;
        tick();
        pcsource = 2'b00;
        ack_drv  = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h300) begin n_fail++; $display("FAIL redir_over_pc actual=%h required=300", pc); end
        n_cmp++; if (inst !== word_at(32'h0)) begin n_fail++; $display("FAIL redir_over_inst actual=%h required=%h", inst, word_at(32'h0)); end
        ack_drv = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        ack_drv  = 1'b1;
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFC;
        tick();
        pcsource = 2'b00;
        n_cmp++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 actual=%h/%h required=fffffffc/0", pc, pc4); end
        tick();
        n_cmp++; if (pc !== 32'h0 || dpc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc actual=%h/%h required=0/0", pc, dpc4); end
        n_cmp++; if (inst !== word_at(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_inst actual=%h required=%h", inst, word_at(32'hFFFF_FFFC)); end
        ack_drv = 1'b0;
    endtask

    task automatic test_reset_ir();
        do_reset();
        ack_drv = 1'b1;
        tick();
        ack_drv  = 1'b0;
        we_pc_ir = 1'b0;
        reset_ir = 1'b1;
        tick();
        n_cmp++; if (inst !== 32'h0 || dpc4 !== 32'h0) begin n_fail++; $display("FAIL rir_ir actual=%h/%h required=0/0", inst, dpc4); end
        n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rir_pc actual=%h required=4", pc); end
        reset_ir = 1'b0;
        we_pc_ir = 1'b1;
        tick();
        reset   = 1'b1;
        ack_drv = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h0 || inst !== 32'h0) begin n_fail++; $display("FAIL midrst actual=%h/%h required=0/0", pc, inst); end
        reset   = 1'b0;
        ack_drv = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h0 || inst !== 32'h0) begin n_fail++; $display("FAIL midrst_stale actual=%h/%h required=0/0", pc, inst); end
    endtask

`ifdef IF_PERF_EN
    task automatic test_perf();
        do_reset();
        n_cmp++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin n_fail++; $display("FAIL perf_rst actual=%0d/%0d required=0/0", fetch_cnt, stall_cnt); end
        ack_drv = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        we_pc_ir = 1'b0;
        tick();
        ack_drv = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        we_pc_ir = 1'b1;
        tick();
        ack_drv = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        ack_drv = 1'b0;
        n_cmp++; if (fetch_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_fetch actual=%0d required=10", fetch_cnt); end
        n_cmp++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL perf_stall actual=%0d required=4", stall_cnt); end
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        pcsource = 2'b00;
        bpc      = '0;
        rpc      = '0;
        jpc      = '0;
        we_pc_ir = 1'b1;
        reset_ir = 1'b0;
        ack_drv  = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait();
        test_hold();
        test_jump();
        test_redir_overwrite();
        test_wrap();
        test_reset_ir();
`ifdef IF_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
